mesm6_muldiv: RTL and testbench
===============================

# mesm6_muldiv

Parametrised iterative integer multiply/divide engine for the MESM-6 arithmetic unit, retiring STEP bits per cycle. It supplies the mantissa product and quotient that the main ALU's floating multiply and divide operations need. Its hi/lo result pair maps onto the accumulator and Y register. It has a start/done handshake and a synchronous reset, so the ALU sequencer can issue an operation and wait on done.

## Interface
- WIDTH, 41: operand width, two's complement (mantissa plus sign); legal range 4..64.
- STEP, 1: bits retired per iteration cycle; legal range 1..8.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; honoured only while ready=1.
- op  in  1  0 = multiply, 1 = divide; sampled with start.
- a  in  WIDTH  multiplicand / dividend; sampled with start.
- b  in  WIDTH  multiplier / divisor; sampled with start.
- ready  out  1  engine idle and able to accept start.
- done  out  1  one-cycle pulse when results are valid.
- hi  out  WIDTH  multiply: product bits [2W-1:W]; divide: remainder.
- lo  out  WIDTH  multiply: product bits [W-1:0]; divide: quotient.
- div_zero  out  1  divisor was zero; held with the results.
- ovfl  out  1  quotient overflow; held with the results.

## Operation
- Reset values: ready=1, done=0, hi=0, lo=0, div_zero=0, ovfl=0, state IDLE.
- Reset wins over every other input in any state. It aborts an operation in progress with no done pulse.
- States:
  - IDLE: ready=1. start=1 latches op and the operand magnitudes (|x| fits in WIDTH unsigned bits, including -2^(WIDTH-1)), latches both signs, clears the count, then goes to ITER.
  - ITER: runs N = ceil(WIDTH/STEP) cycles, then goes to FIX.
  - FIX: applies signs, registers hi/lo/flags, pulses done, returns to IDLE.
- Multiply: unsigned shift-add on a 2·WIDTH partial product, consuming STEP multiplier bits per cycle, LSB first. The last cycle consumes only the remaining bits. The product is negated if the operand signs differ. The result is the exact signed 2·WIDTH product. ovfl=0 and div_zero=0.
- Divide: restoring division, STEP quotient bits per cycle, MSB first.
  - Quotient truncates toward zero.
  - The remainder takes the sign of the dividend, and |r| < |b|.
- Divide by zero: detected in IDLE at start. The engine skips ITER and goes straight to FIX, giving lo = all ones, hi = a, div_zero=1.
- Overflow: a = -2^(WIDTH-1) with b = -1 gives lo = -2^(WIDTH-1), hi = 0, ovfl=1.
- Results and flags hold from the done cycle until the next accepted start, which clears the flags.
- start while ready=0 is ignored. It is not queued.

## Timing
- start is sampled at edge 0. ITER occupies edges 1..N, and FIX is edge N+1.
- done and the results are visible after edge N+1, for exactly one cycle.
- Divide by zero: FIX is edge 1, so done is visible after edge 1.
- ready falls after edge 0 and rises in the same cycle as done. A back-to-back start issued during the done cycle is accepted at edge N+2.
- With the default parameters, N=41 and latency is 42 cycles. With STEP=4, N=11 and latency is 12 cycles.
- No combinational path runs from inputs to outputs.

## Structure
- mesm6_pkg holds:
  - the typedef enum for op (MD_MUL, MD_DIV);
  - the state enum (MD_IDLE, MD_ITER, MD_FIX);
  - the localparam helper for N.
- Sub-module mesm6_muldiv_step is combinational and STEP-wide. It performs one iteration, either STEP shift-adds or STEP restoring subtract stages, selected by op. The top level holds the FSM, counter, sign handling and output registers.

## Test plan
- Multiply, defaults: a=3, b=-5 → done after edge 42, hi=41'h1FFFFFFFFFF, lo=41'h1FFFFFFFFF1, ovfl=0.
- Divide, defaults: a=-7, b=2 → lo=-3, hi=-1. a=7, b=-2 → lo=-3, hi=1. Both complete in 42 cycles.
- Divide by zero: a=123, b=0 → done after edge 1, lo=all ones, hi=123, div_zero=1. The next start clears div_zero.
- Overflow, WIDTH=8: a=8'h80, b=8'hFF → lo=8'h80, hi=0, ovfl=1. Multiply 8'h80×8'h80 → {hi,lo}=16'h4000.
- STEP=4: random signed pairs match the STEP=1 results, with done after edge 12. A back-to-back start in the done cycle is accepted. start while busy is ignored.
- Reset asserted at edge 10 of a multiply → all outputs at reset values next cycle, no done pulse, ready=1.

Source files
------------

// File: rtl/mesm6_pkg.sv
// Shared types and helpers for the MESM-6 iterative multiply/divide engine.
package mesm6_pkg;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_ITER = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Iteration cycles needed to retire width bits at step bits per cycle.
  function automatic int md_iters(input int width, input int step);
    return (width + step - 1) / step;
  endfunction

endpackage

// File: rtl/mesm6_muldiv_step.sv
// One iteration of the engine: STEP shift-add stages (multiply) or STEP
// restoring subtract stages (divide), purely combinational.
module mesm6_muldiv_step
  import mesm6_pkg::*;
#(
  parameter int WIDTH = 41,
  parameter int STEP  = 1,
  parameter int QW    = 41
) (
  input  md_op_e               op,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [2*WIDTH-1:0]   mcand,
  input  logic [QW-1:0]        sreg,
  output logic [2*WIDTH-1:0]   acc_nxt,
  output logic [2*WIDTH-1:0]   mcand_nxt,
  output logic [QW-1:0]        sreg_nxt
);

  logic [WIDTH:0] rem;
  logic [WIDTH:0] dvsr;

  // NOTE: every output and temporary gets a default first so no path through
  // this block leaves a variable unassigned, which would infer a latch.
  always_comb begin
    acc_nxt   = acc;
    mcand_nxt = mcand;
    sreg_nxt  = sreg;
    rem       = acc[WIDTH:0];
    dvsr      = {1'b0, mcand[WIDTH-1:0]};
    if (op == MD_MUL) begin
      // Multiplier bits leave LSB first; zeros shifted in past the top make
      // a short final iteration add nothing.
      for (int i = 0; i < STEP; i++) begin
        if (sreg_nxt[0]) acc_nxt = acc_nxt + mcand_nxt;
        mcand_nxt = mcand_nxt << 1;
        sreg_nxt  = sreg_nxt >> 1;
      end
    end else begin
      // Dividend shifts out MSB first while quotient bits shift in at the LSB.
      for (int i = 0; i < STEP; i++) begin
        rem      = {rem[WIDTH-1:0], sreg_nxt[QW-1]};
        sreg_nxt = sreg_nxt << 1;
        if (rem >= dvsr) begin
          rem         = rem - dvsr;
          sreg_nxt[0] = 1'b1;
        end
      end
      acc_nxt          = '0;
      acc_nxt[WIDTH:0] = rem;
    end
  end

endmodule

// File: rtl/mesm6_muldiv.sv
// Iterative signed multiply/divide engine with start/done handshake; operates
// on magnitudes and applies the operand signs in a final fix-up cycle.
module mesm6_muldiv
  import mesm6_pkg::*;
#(
  parameter int WIDTH = 41,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic             ovfl
);

  localparam int N  = md_iters(WIDTH, STEP);
  localparam int QW = N * STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e state, state_nxt;
  logic [CW-1:0] count;
  md_op_e        op_r;
  logic          sign_a, sign_b, dz_r, ov_r;

  logic [2*WIDTH-1:0] acc, mcand, acc_nxt, mcand_nxt;
  logic [QW-1:0]      sreg, sreg_nxt;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               last_iter, start_dz, start_ov;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, dvd_s;

  // Magnitudes fit WIDTH unsigned bits, including the most negative value.
  assign mag_a     = a[WIDTH-1] ? -a : a;
  assign mag_b     = b[WIDTH-1] ? -b : b;
  assign last_iter = (count == CW'(N - 1));
  assign start_dz  = (md_op_e'(op) == MD_DIV) && (b == '0);
  assign start_ov  = (md_op_e'(op) == MD_DIV) && (a == MIN_VAL) && (b == '1);
  assign ready     = (state == MD_IDLE);

  mesm6_muldiv_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .QW    (QW)
  ) u_step (
    .op        (op_r),
    .acc       (acc),
    .mcand     (mcand),
    .sreg      (sreg),
    .acc_nxt   (acc_nxt),
    .mcand_nxt (mcand_nxt),
    .sreg_nxt  (sreg_nxt)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      MD_IDLE: if (start) state_nxt = start_dz ? MD_FIX : MD_ITER;
      MD_ITER: if (last_iter) state_nxt = MD_FIX;
      MD_FIX:  state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // Sign fix-up; for a zero divisor sreg still holds |a|, so dvd_s rebuilds a.
  always_comb begin
    prod_s = (sign_a ^ sign_b) ? -acc : acc;
    quo_s  = (sign_a ^ sign_b) ? -sreg[WIDTH-1:0] : sreg[WIDTH-1:0];
    rem_s  = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    dvd_s  = sign_a ? -sreg[WIDTH-1:0] : sreg[WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MD_IDLE;
      count    <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      ovfl     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == MD_FIX);
      unique case (state)
        MD_IDLE: if (start) begin
          count    <= '0;
          div_zero <= 1'b0;
          ovfl     <= 1'b0;
        end
        MD_ITER: count <= count + 1'b1;
        MD_FIX: begin
          if (op_r == MD_MUL) begin
            {hi, lo} <= prod_s;
          end else if (dz_r) begin
            hi <= dvd_s;
            lo <= '1;
          end else begin
            hi <= rem_s;
            lo <= quo_s;
          end
          div_zero <= dz_r;
          ovfl     <= ov_r;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the working datapath is always loaded before use, so it carries no
  // reset; only control state and visible outputs are reset.
  always_ff @(posedge clk) begin
    if (state == MD_IDLE && start) begin
      op_r   <= md_op_e'(op);
      sign_a <= a[WIDTH-1];
      sign_b <= b[WIDTH-1];
      dz_r   <= start_dz;
      ov_r   <= start_ov;
      acc    <= '0;
      if (md_op_e'(op) == MD_MUL) begin
        mcand <= (2*WIDTH)'(mag_a);
        sreg  <= QW'(mag_b);
      end else begin
        mcand <= (2*WIDTH)'(mag_b);
        sreg  <= QW'(mag_a);
      end
    end else if (state == MD_ITER) begin
      acc   <= acc_nxt;
      mcand <= mcand_nxt;
      sreg  <= sreg_nxt;
    end
  end

endmodule

// File: tb/tb_mesm6_muldiv.sv
// Self-checking bench for mesm6_muldiv: three parameterisations checked every
// cycle against a plain-arithmetic model, plus literal expectations.
module tb_mesm6_muldiv;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  start_s = '0;
  logic [2:0]  op_s = '0;
  logic [63:0] a_s [3];
  logic [63:0] b_s [3];
  wire  [2:0]  ready_s, done_s, dz_s, ov_s;
  wire  [40:0] hi0, lo0, hi2, lo2;
  wire  [7:0]  hi1, lo1;
  wire  [63:0] hi_v [3];
  wire  [63:0] lo_v [3];

  assign hi_v[0] = {23'd0, hi0};
  assign lo_v[0] = {23'd0, lo0};
  assign hi_v[1] = {56'd0, hi1};
  assign lo_v[1] = {56'd0, lo1};
  assign hi_v[2] = {23'd0, hi2};
  assign lo_v[2] = {23'd0, lo2};

  mesm6_muldiv #(.WIDTH(41), .STEP(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .op(op_s[0]),
    .a(a_s[0][40:0]), .b(b_s[0][40:0]), .ready(ready_s[0]), .done(done_s[0]),
    .hi(hi0), .lo(lo0), .div_zero(dz_s[0]), .ovfl(ov_s[0]));

  mesm6_muldiv #(.WIDTH(8), .STEP(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .op(op_s[1]),
    .a(a_s[1][7:0]), .b(b_s[1][7:0]), .ready(ready_s[1]), .done(done_s[1]),
    .hi(hi1), .lo(lo1), .div_zero(dz_s[1]), .ovfl(ov_s[1]));

  mesm6_muldiv #(.WIDTH(41), .STEP(4)) u_dut2 (
    .clk(clk), .reset(reset), .start(start_s[2]), .op(op_s[2]),
    .a(a_s[2][40:0]), .b(b_s[2][40:0]), .ready(ready_s[2]), .done(done_s[2]),
    .hi(hi2), .lo(lo2), .div_zero(dz_s[2]), .ovfl(ov_s[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_chk = 0;
  int  n_fail = 0;
  bit  armed = 1'b0;
  int  exp_cyc [3] = '{-1, -1, -1};
  int  iss_c   [3] = '{-1, -1, -1};
  logic [63:0] e_hi [3];
  logic [63:0] e_lo [3];
  bit  e_dz [3];
  bit  e_ov [3];

  function automatic int wof(input int k);
    return (k == 1) ? 8 : 41;
  endfunction

  function automatic int sof(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Exact signed arithmetic on wide integers.
  function automatic void model(input int w, input bit o, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] hi,
                                output logic [63:0] lo, output bit dz, output bit ov);
    logic signed [127:0] sa, sb, p, q, r;
    logic [127:0] m;
    m  = (128'd1 << w) - 128'd1;
    sa = $signed({64'd0, a} & m);
    sb = $signed({64'd0, b} & m);
    if (sa[w-1]) sa = sa - $signed(128'd1 << w);
    if (sb[w-1]) sb = sb - $signed(128'd1 << w);
    dz = 1'b0;
    ov = 1'b0;
    if (!o) begin
      p  = sa * sb;
      lo = 64'(p & m);
      hi = 64'((p >>> w) & m);
    end else if (sb == 0) begin
      dz = 1'b1;
      lo = 64'(m);
      hi = 64'(sa & m);
    end else if (sa == -$signed(128'd1 << (w - 1)) && sb == -128'sd1) begin
      ov = 1'b1;
      lo = 64'(128'd1 << (w - 1));
      hi = 64'd0;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = 64'(q & m);
      hi = 64'(r & m);
    end
  endfunction

  // Single compare process: handshake every cycle, results on the done cycle.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("ready%0d", k), 64'(ready_s[k]),
              64'(!((cyc > iss_c[k]) && (cyc < exp_cyc[k]))));
        if (cyc == exp_cyc[k]) begin
          check($sformatf("done%0d", k), 64'(done_s[k]), 64'd1);
          check($sformatf("hi%0d", k), hi_v[k], e_hi[k]);
          check($sformatf("lo%0d", k), lo_v[k], e_lo[k]);
          check($sformatf("div_zero%0d", k), 64'(dz_s[k]), 64'(e_dz[k]));
          check($sformatf("ovfl%0d", k), 64'(ov_s[k]), 64'(e_ov[k]));
        end else begin
          check($sformatf("no_done%0d", k), 64'(done_s[k]), 64'd0);
        end
        if (iss_c[k] >= 0 && cyc == iss_c[k] + 1) begin
          check($sformatf("flags_clr%0d", k), {62'd0, dz_s[k], ov_s[k]}, 64'd0);
        end
      end
    end
  end

  task automatic issue(input int k, input bit o, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] h, l;
    bit dz, ov;
    int w, n;
    w = wof(k);
    n = (w + sof(k) - 1) / sof(k);
    model(w, o, a, b, h, l, dz, ov);
    start_s[k] = 1'b1;
    op_s[k]    = o;
    a_s[k]     = a & mask_of(w);
    b_s[k]     = b & mask_of(w);
    iss_c[k]   = cyc;
    exp_cyc[k] = cyc + 1 + (dz ? 1 : n + 1);
    e_hi[k] = h;
    e_lo[k] = l;
    e_dz[k] = dz;
    e_ov[k] = ov;
  endtask

  task automatic poke(input int k, input bit o, input logic [63:0] a, input logic [63:0] b);
    start_s[k] = 1'b1;
    op_s[k]    = o;
    a_s[k]     = a & mask_of(wof(k));
    b_s[k]     = b & mask_of(wof(k));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    start_s = '0;
  endtask

  task automatic wait_idle(input int k);
    for (int i = 0; i < 200 && cyc < exp_cyc[k]; i++) step();
    if (cyc < exp_cyc[k]) check($sformatf("timeout%0d", k), 64'd1, 64'd0);
  endtask

  task automatic wait_until(input int c);
    for (int i = 0; i < 200 && cyc < c; i++) step();
  endtask

  typedef struct { bit o; logic [63:0] a; logic [63:0] b; } vec_t;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] h, l, ra, rb;
    bit dz, ov;
    int c0;
    vec_t v8 [8];

    for (int k = 0; k < 3; k++) begin
      a_s[k] = '0;
      b_s[k] = '0;
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ready%0d", k), 64'(ready_s[k]), 64'd1);
      check($sformatf("rst_done%0d", k), 64'(done_s[k]), 64'd0);
      check($sformatf("rst_hi%0d", k), hi_v[k], 64'd0);
      check($sformatf("rst_lo%0d", k), lo_v[k], 64'd0);
      check($sformatf("rst_flags%0d", k), {62'd0, dz_s[k], ov_s[k]}, 64'd0);
    end
    #1;
    reset = 1'b0;
    armed = 1'b1;

    // Pin the model to hand-computed values.
    model(41, 1'b0, 64'd3, -64'sd5, h, l, dz, ov);
    check("model_mul_hi", h, 64'h1FF_FFFF_FFFF);
    check("model_mul_lo", l, 64'h1FF_FFFF_FFF1);
    model(41, 1'b1, -64'sd7, 64'd2, h, l, dz, ov);
    check("model_div_q", l, 64'h1FF_FFFF_FFFD);
    check("model_div_r", h, 64'h1FF_FFFF_FFFF);
    model(8, 1'b1, 64'h80, 64'hFF, h, l, dz, ov);
    check("model_ovfl", {h[7:0], l[7:0], 7'd0, ov}, {8'h00, 8'h80, 8'h01});
    model(8, 1'b0, 64'h80, 64'h80, h, l, dz, ov);
    check("model_minsq", {h[7:0], l[7:0]}, 16'h4000);

    // Default parameters: multiply latency and literal results.
    step();
    c0 = cyc;
    issue(0, 1'b0, 64'd3, -64'sd5);
    step();
    wait_until(c0 + 43);
    check("mul_done_edge42", 64'(done_s[0]), 64'd1);
    check("mul_hi_lit", hi_v[0], 64'h1FF_FFFF_FFFF);
    check("mul_lo_lit", lo_v[0], 64'h1FF_FFFF_FFF1);

    issue(0, 1'b1, -64'sd7, 64'd2);
    step();
    wait_idle(0);
    check("div_m7_2_lo", lo_v[0], 64'h1FF_FFFF_FFFD);
    check("div_m7_2_hi", hi_v[0], 64'h1FF_FFFF_FFFF);

    issue(0, 1'b1, 64'd7, -64'sd2);
    step();
    wait_idle(0);
    check("div_7_m2_lo", lo_v[0], 64'h1FF_FFFF_FFFD);
    check("div_7_m2_hi", hi_v[0], 64'd1);

    c0 = cyc;
    issue(0, 1'b1, 64'd123, 64'd0);
    step();
    step();
    check("dz_done_edge1", 64'(done_s[0]), 64'd1);
    check("dz_flag", 64'(dz_s[0]), 64'd1);
    check("dz_lo", lo_v[0], 64'h1FF_FFFF_FFFF);
    check("dz_hi", hi_v[0], 64'd123);
    issue(0, 1'b0, 64'd5, 64'd6);
    step();
    check("dz_cleared", 64'(dz_s[0]), 64'd0);
    wait_idle(0);

    // WIDTH=8, STEP=3: overflow, most-negative square and a directed table.
    issue(1, 1'b1, 64'h80, 64'hFF);
    step();
    wait_idle(1);
    check("ovfl8_lo", lo_v[1], 64'h80);
    check("ovfl8_hi", hi_v[1], 64'h00);
    check("ovfl8_flag", 64'(ov_s[1]), 64'd1);
    issue(1, 1'b0, 64'h80, 64'h80);
    step();
    wait_idle(1);
    check("minsq8", {hi_v[1][7:0], lo_v[1][7:0]}, 64'h4000);
    v8 = '{'{1'b1, -64'sd128, 64'd3}, '{1'b1, 64'd100, -64'sd7},
           '{1'b0, 64'd127, -64'sd128}, '{1'b1, 64'd5, 64'd0},
           '{1'b1, -64'sd1, 64'd100}, '{1'b0, -64'sd1, -64'sd1},
           '{1'b1, 64'd127, 64'd127}, '{1'b1, -64'sd100, 64'd7}};
    foreach (v8[i]) begin
      issue(1, v8[i].o, v8[i].a, v8[i].b);
      step();
      wait_idle(1);
    end

    // STEP=4 latency.
    c0 = cyc;
    issue(2, 1'b1, -64'sd1000, 64'd33);
    step();
    wait_until(c0 + 13);
    check("step4_done_edge12", 64'(done_s[2]), 64'd1);

    // STEP=1 and STEP=4 side by side on the same operands, with busy pokes.
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 3 == 1) rb = 64'($urandom_range(1, 5000));
      if (i % 4 == 2) rb = -rb;
      if (i == 7) begin ra = 64'h100_0000_0000; rb = -64'sd1; end
      if (i == 8) begin ra = 64'h100_0000_0000; rb = 64'h100_0000_0000; end
      issue(0, i[0], ra, rb);
      issue(2, i[0], ra, rb);
      step();
      if (i == 3 || i == 6) begin
        repeat (3) step();
        poke(0, !i[0], 64'd9, 64'd4);
        poke(2, !i[0], 64'd9, 64'd4);
        step();
      end
      wait_idle(2);
      wait_idle(0);
    end

    // Reset at edge 10 of a multiply aborts it without a done pulse.
    c0 = cyc;
    issue(0, 1'b0, 64'd12345, -64'sd678);
    step();
    wait_until(c0 + 10);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_cyc[k] = -1;
      iss_c[k]   = -1;
    end
    step();
    check("rst_mid_ready", 64'(ready_s[0]), 64'd1);
    check("rst_mid_done", 64'(done_s[0]), 64'd0);
    check("rst_mid_hi", hi_v[0], 64'd0);
    check("rst_mid_lo", lo_v[0], 64'd0);
    check("rst_mid_flags", {62'd0, dz_s[0], ov_s[0]}, 64'd0);
    reset = 1'b0;
    repeat (50) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
